pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register: successor to the fixed D/E stage latch.
//  Carries a WIDTH-bit payload (pc/instr/operands packed by the caller) under
//  valid/ready handshake, with 2-entry skid buffer and synchronous flush.
//  Stall from downstream is absorbed without a combinational ready path; a flush
//  inserts a bubble (payload = BUBBLE). Sits between any two CPU stages (F/D, D/E, E/M, M/W).
// PARAMETERS
//  WIDTH          32  payload width in bits (>=1)
//  BUBBLE         0   payload value presented when the stage is empty or flushed (0 = nop)
//  CNT_W          16  width of the saturating stall/bubble performance counters
// PORTS
//  clk            in   1      single clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  flush          in   1      synchronous kill of all held entries (replaces CLR)
//  in_valid       in   1      upstream has a payload
//  in_data        in   WIDTH  upstream payload
//  in_ready       out  1      stage can accept; registered output
//  out_valid      out  1      out_data holds a live entry
//  out_data       out  WIDTH  payload to the next stage; BUBBLE when !out_valid
//  out_ready      in   1      downstream accepts (0 = stall)
//  stall_cnt      out  CNT_W  cycles with out_valid & !out_ready, saturating
//  bubble_cnt     out  CNT_W  cycles with out_ready & !out_valid, saturating
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (reset_n=0, async): state EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1,
//    skid cleared to BUBBLE, both counters 0. Reset mid-transfer discards all entries.
//  - States: EMPTY (main empty), ONE (main full), TWO (main + skid full).
//    EMPTY: in_fire -> ONE, main<=in_data.
//    ONE:   in_fire&out_fire -> ONE, main<=in_data; in_fire&!out_ready -> TWO, skid<=in_data;
//           !in_fire&out_fire -> EMPTY, main<=BUBBLE; else hold.
//    TWO:   out_fire -> ONE, main<=skid, skid<=BUBBLE; else hold. in_ready=0 here.
//  - in_ready registered: 1 in EMPTY/ONE, 0 in TWO; never depends on out_ready same cycle.
//  - Latency: 1 cycle in_fire -> out_valid when not stalled; full throughput
//    (1 entry/cycle) under continuous out_ready=1.
//  - Order preserved: skid entry always leaves after main entry.
//  - flush=1 (sync, highest priority): next state EMPTY, main and skid <= BUBBLE,
//    out_valid<=0, in_ready<=1. An in_fire in the same cycle is accepted and discarded.
//    An out_fire in the same cycle completes normally (downstream consumed it).
//  - Counters: increment per qualifying cycle, saturate at 2^CNT_W-1, cleared only by
//    reset; flush does not clear them. Flush cycle itself counts per current outputs.
//  - out_data == BUBBLE whenever out_valid==0 (no stale payload visible).
// STRUCTURE
//  - Shared package pipe_pkg: state encoding (EMPTY/ONE/TWO, 2 bits), default
//    BUBBLE/nop constant, counter width default.
//  - One sub-module: pipe_sat_counter (CNT_W, inc, clk, reset_n) used twice.
//  - Storage: main and skid WIDTH-bit regs plus state reg; no memories.
// TESTING
//  1 Reset: hold reset_n=0 with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, counters 0.
//  2 Stream: in_data 1..8 back-to-back, out_ready=1 -> out_data 1..8 one cycle later, no gaps,
//    in_ready stays 1, bubble_cnt counts only pre-fill cycle.
//  3 Stall: send A,B,C, out_ready=0 after A arrives -> A held, B in skid, in_ready=0, C held
//    upstream; release -> A,B,C in order; stall_cnt = stalled cycles.
//  4 Flush in TWO with in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1,
//    input payload lost, counters unchanged by flush.
//  5 Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds.
//  6 Async reset asserted mid-stall between clock edges -> outputs clear immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register family.
//
// Contents:
//   stage_state_e  occupancy of a stage: EMPTY (nothing held), ONE (main
//                  register full), TWO (main plus skid register full)
//   NOP_BUBBLE     default payload shown when a stage holds nothing (a nop)
//   DEFAULT_WIDTH  default payload width
//   DEFAULT_CNT_W  default width of the performance counters
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned NOP_BUBBLE    = 0;
  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage : pipe_pkg

// File: rtl/pipe_sat_counter.sv
// Saturating event counter used for the stage performance statistics.
//
// Ports:
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset, clears the count
//   inc      in   1      count this cycle
//   cnt      out  CNT_W  current count, sticks at all-ones
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: add one on a qualifying cycle unless already at the ceiling,
  // so a long stall can never wrap the statistic back to a small number.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : pipe_sat_counter

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a two-entry skid buffer.
//
// Moves a WIDTH-bit payload between two CPU stages under a valid/ready
// handshake. in_ready is a register, so a downstream stall never reaches the
// upstream stage through combinational logic; the skid register catches the
// one entry that may arrive while the stall is being noticed. flush empties
// the stage synchronously and shows BUBBLE downstream.
//
// Ports:
//   clk         in   1      rising-edge clock
//   reset_n     in   1      asynchronous active-low reset
//   flush       in   1      synchronous kill of all held entries
//   in_valid    in   1      upstream offers a payload
//   in_data     in   WIDTH  upstream payload
//   in_ready    out  1      stage accepts this cycle (registered)
//   out_valid   out  1      out_data holds a live entry
//   out_data    out  WIDTH  payload to next stage, BUBBLE when !out_valid
//   out_ready   in   1      downstream accepts (0 = stall)
//   stall_cnt   out  CNT_W  cycles with out_valid & !out_ready (saturating)
//   bubble_cnt  out  CNT_W  cycles with out_ready & !out_valid (saturating)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned     WIDTH  = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_BUBBLE),
  parameter int unsigned     CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  stage_state_e     state_q;
  stage_state_e     state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             inReady_q;
  logic             inReady_d;

  logic inFire;
  logic outFire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = inReady_q;
  assign inFire    = in_valid & inReady_q;
  assign outFire   = out_valid & out_ready;

  // Main is the head of the stage and is the only register driven out. Every
  // path that empties it writes BUBBLE, so no stale payload can show while
  // out_valid is low.
  assign out_data = main_q;

  // Next-state and datapath decode. The skid entry is always younger than
  // the main entry, so it only ever moves into main, never straight out.
  // Flush overrides everything: an entry accepted in the same cycle is lost,
  // and one handed downstream in the same cycle has already been consumed.
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (inFire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          main_d = in_data;
        end else if (inFire) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (outFire) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      TWO: begin
        if (outFire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase

    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end

    // Ready is a function of where we will be, not of out_ready now.
    inReady_d = (state_d != TWO);
  end

  // State and payload registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= EMPTY;
      main_q    <= BUBBLE;
      skid_q    <= BUBBLE;
      inReady_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      inReady_q <= inReady_d;
    end
  end

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) uStallCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (out_valid & ~out_ready),
    .cnt     (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) uBubbleCnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (out_ready & ~out_valid),
    .cnt     (bubble_cnt)
  );

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. Two instances share all inputs: one with wide
// counters and one with 4-bit counters so saturation is reachable quickly.
// Expected outputs come from a queue model of the stage contents.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        inReadyA;
  logic        outValidA;
  logic [15:0] outDataA;
  logic [15:0] stallA;
  logic [15:0] bubbleA;

  logic        inReadyB;
  logic        outValidB;
  logic [15:0] outDataB;
  logic [3:0]  stallB;
  logic [3:0]  bubbleB;

  int checkCnt = 0;
  int passCnt  = 0;

  // Model state: entries held by the stage, oldest first.
  logic [15:0] modelQ[$];
  bit          mInReady;
  int          mStall;
  int          mBubble;
  int          mStall4;
  int          mBubble4;

  pipe_stage_skid #(
    .WIDTH (16),
    .CNT_W (16)
  ) dutA (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (inReadyA),
    .out_valid  (outValidA),
    .out_data   (outDataA),
    .out_ready  (out_ready),
    .stall_cnt  (stallA),
    .bubble_cnt (bubbleA)
  );

  pipe_stage_skid #(
    .WIDTH (16),
    .CNT_W (4)
  ) dutB (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (inReadyB),
    .out_valid  (outValidB),
    .out_data   (outDataB),
    .out_ready  (out_ready),
    .stall_cnt  (stallB),
    .bubble_cnt (bubbleB)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts, and reports any mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    mInReady = 1'b1;
    mStall   = 0;
    mBubble  = 0;
    mStall4  = 0;
    mBubble4 = 0;
  endtask

  // Compare both instances against the model's view of the current cycle.
  task automatic checkOutput();
    logic        expValid;
    logic [15:0] expData;
    expValid = (modelQ.size() > 0);
    expData  = expValid ? modelQ[0] : 16'h0000;
    check("outValidA", 32'(outValidA), 32'(expValid));
    check("outDataA",  32'(outDataA),  32'(expData));
    check("inReadyA",  32'(inReadyA),  32'(mInReady));
    check("stallCntA", 32'(stallA),    32'(mStall));
    check("bubbleCntA",32'(bubbleA),   32'(mBubble));
    check("outValidB", 32'(outValidB), 32'(expValid));
    check("outDataB",  32'(outDataB),  32'(expData));
    check("inReadyB",  32'(inReadyB),  32'(mInReady));
    check("stallCntB", 32'(stallB),    32'(mStall4));
    check("bubbleCntB",32'(bubbleB),   32'(mBubble4));
  endtask

  // Advance the model across one rising edge using the inputs present now.
  task automatic updateModel();
    bit v;
    bit inF;
    bit outF;
    v    = (modelQ.size() > 0);
    inF  = in_valid && mInReady;
    outF = v && out_ready;
    if (v && !out_ready) begin
      if (mStall < 65535) mStall++;
      if (mStall4 < 15) mStall4++;
    end
    if (out_ready && !v) begin
      if (mBubble < 65535) mBubble++;
      if (mBubble4 < 15) mBubble4++;
    end
    if (flush) begin
      modelQ.delete();
      mInReady = 1'b1;
    end else begin
      if (outF) void'(modelQ.pop_front());
      if (inF) modelQ.push_back(in_data);
      mInReady = (modelQ.size() < 2);
    end
  endtask

  // One cycle: drive at the falling edge, check, step through the rising edge.
  task automatic applyStimulus(input bit iv, input logic [15:0] id, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    out_ready = 1'b1;
    modelReset();

    // Reset held with upstream offering data: stage stays empty.
    repeat (2) @(negedge clk);
    #1;
    checkOutput();
    check("resetOutData", 32'(outDataA), 32'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // Back-to-back stream 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b1, 1'b0);
    check("streamLast", 32'(outDataA), 32'h8);
    check("bubblePrefill", 32'(bubbleA), 32'h1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Stall: A then B arrive while downstream stops; C waits upstream.
    applyStimulus(1'b1, 16'h00A0, 1'b1, 1'b0);
    applyStimulus(1'b1, 16'h00B0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 16'h00C0, 1'b0, 1'b0);
    check("stallInReady", 32'(inReadyA), 32'h0);
    check("stallHeadA", 32'(outDataA), 32'h00A0);
    check("stallCount", 32'(stallA), 32'h4);
    repeat (2) applyStimulus(1'b1, 16'h00C0, 1'b1, 1'b0);
    check("releaseC", 32'(outDataA), 32'h00C0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);

    // Fill both entries, then flush while upstream still offers data.
    applyStimulus(1'b1, 16'h00D0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00E0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00F0, 1'b0, 1'b1);
    check("flushValid", 32'(outValidA), 32'h0);
    check("flushData", 32'(outDataA), 32'h0);
    check("flushReady", 32'(inReadyA), 32'h1);
    check("flushStall", 32'(stallA), 32'h6);

    // Long stall drives the 4-bit counter to its ceiling and holds it.
    applyStimulus(1'b1, 16'h0123, 1'b0, 1'b0);
    repeat (22) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    check("satStallB", 32'(stallB), 32'hF);
    check("wideStallA", 32'(stallA), 32'd28);

    // Asynchronous reset between edges clears outputs at once.
    in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // Random traffic, occasional flush.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    #1;
    checkOutput();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule : tb_pipe_stage_skid
